msx_rom_mapper_gen: RTL and testbench

//  Clocked, multi-mode MSX cartridge ROM mapper; successor to the fixed Konami-SCC mapper.

---
 rtl/msx_rom_mapper_gen.sv | 160 ++++++++++++++++
 tb/tb_msx_rom_mapper_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/msx_rom_mapper_gen.sv
// Multi-mode MSX cartridge ROM mapper (Konami-SCC, Konami, ASCII8, ASCII16).
// Z80 writes into the slot are synchronised, edge-detected and decoded into
// four bank registers. The read path maps the current address onto the upper
// flash address lines and drives the flash chip select with no clock latency.
module msx_rom_mapper_gen #(
  parameter int BANK_W      = 6,
  parameter int SEL_W       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        outer_sel,
  input  logic [15:0]             a,
  input  logic [7:0]              d,
  input  logic                    sltsl_n,
  input  logic                    rd_n,
  input  logic                    wr_n,
  output logic                    rom_cs_n,
  output logic [SEL_W+BANK_W-1:0] flash_a_hi,
  output logic                    bank_upd,
  output logic [1:0]              mode_q
);

  localparam logic [1:0] MODE_KONAMI_SCC = 2'd0;
  localparam logic [1:0] MODE_KONAMI     = 2'd1;
  localparam logic [1:0] MODE_ASCII8     = 2'd2;
  localparam logic [1:0] MODE_ASCII16    = 2'd3;

  // ASCII16 registers hold one bit less than the 8KB modes: a[13] supplies the LSB.
  localparam logic [BANK_W-1:0] LOW_MASK = BANK_W'((1 << (BANK_W - 1)) - 1);

  logic [SYNC_STAGES-1:0]     sltsl_sync_q, sltsl_sync_d;
  logic [SYNC_STAGES-1:0]     wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0]     fill_q, fill_d;
  logic                       armed_q, armed_d;
  logic                       prev_wr_q, prev_wr_d;
  logic                       bank_upd_q, bank_upd_d;
  logic [1:0]                 mode_d;
  logic [3:0][BANK_W-1:0]     bank_reg_q, bank_reg_d;

  logic                       wr_act;
  logic                       pipe_busy;
  logic                       commit;
  logic                       hit;
  logic [1:0]                 hit_idx;
  logic [BANK_W-1:0]          wr_data;
  logic                       in_win;
  logic [1:0]                 page;
  logic [BANK_W-1:0]          r16;
  logic [BANK_W-1:0]          bank;
  logic                       unused_bits;

  assign unused_bits = ^{a[10:0], d};

  // Decode which bank register (if any) a write at the live address targets.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    case (mode_q)
      MODE_KONAMI_SCC: begin
        case (a[15:11])
          5'h0A:   begin hit = 1'b1; hit_idx = 2'd0; end
          5'h0E:   begin hit = 1'b1; hit_idx = 2'd1; end
          5'h12:   begin hit = 1'b1; hit_idx = 2'd2; end
          5'h16:   begin hit = 1'b1; hit_idx = 2'd3; end
          default: hit = 1'b0;
        endcase
      end
      MODE_KONAMI: begin
        case (a[15:13])
          3'd3:    begin hit = 1'b1; hit_idx = 2'd1; end
          3'd4:    begin hit = 1'b1; hit_idx = 2'd2; end
          3'd5:    begin hit = 1'b1; hit_idx = 2'd3; end
          default: hit = 1'b0;
        endcase
      end
      MODE_ASCII8: begin
        if (a[15:13] == 3'd3) begin
          hit     = 1'b1;
          hit_idx = a[12:11];
        end
      end
      default: begin
        case (a[15:11])
          5'h0C:   begin hit = 1'b1; hit_idx = 2'd0; end
          5'h0E:   begin hit = 1'b1; hit_idx = 2'd1; end
          default: hit = 1'b0;
        endcase
      end
    endcase
    wr_data = (mode_q == MODE_ASCII16) ? (d[BANK_W-1:0] & LOW_MASK) : d[BANK_W-1:0];
  end

  // Next state: strobe synchronisers, one-commit-per-strobe edge detect, bank registers.
  // The armed flag keeps a strobe already in progress at reset release from committing:
  // it only sets once the synchroniser has refilled with real samples and seen no strobe.
  always_comb begin
    sltsl_sync_d = {sltsl_sync_q[SYNC_STAGES-2:0], sltsl_n};
    wr_sync_d    = {wr_sync_q[SYNC_STAGES-2:0], wr_n};
    fill_d       = {fill_q[SYNC_STAGES-2:0], 1'b1};
    wr_act       = ~sltsl_sync_q[SYNC_STAGES-1] & ~wr_sync_q[SYNC_STAGES-1];
    pipe_busy    = |(~sltsl_sync_q & ~wr_sync_q);
    armed_d      = armed_q | (fill_q[SYNC_STAGES-1] & ~pipe_busy);
    commit       = wr_act & ~prev_wr_q & armed_q;
    prev_wr_d    = wr_act;
    bank_upd_d   = commit & hit;
    mode_d       = mode_q;
    bank_reg_d   = bank_reg_q;
    if (commit && hit) begin
      bank_reg_d[hit_idx] = wr_data;
    end
    if (!reset_n) begin
      sltsl_sync_d = '1;
      wr_sync_d    = '1;
      fill_d       = '0;
      armed_d      = 1'b0;
      prev_wr_d    = 1'b1;
      bank_upd_d   = 1'b0;
      mode_d       = mode;
      if (mode == MODE_KONAMI_SCC || mode == MODE_KONAMI) begin
        bank_reg_d[0] = BANK_W'(0);
        bank_reg_d[1] = BANK_W'(1);
        bank_reg_d[2] = BANK_W'(2);
        bank_reg_d[3] = BANK_W'(3);
      end else begin
        bank_reg_d = '0;
      end
    end
  end

  // State register; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    sltsl_sync_q <= sltsl_sync_d;
    wr_sync_q    <= wr_sync_d;
    fill_q       <= fill_d;
    armed_q      <= armed_d;
    prev_wr_q    <= prev_wr_d;
    bank_upd_q   <= bank_upd_d;
    mode_q       <= mode_d;
    bank_reg_q   <= bank_reg_d;
  end

  // Combinational read path: select the page register and build the flash high address.
  always_comb begin
    in_win = (a >= 16'h4000) && (a <= 16'hBFFF);
    page   = in_win ? (a[14:13] - 2'd2) : a[14:13];
    r16    = bank_reg_q[{1'b0, page[1]}];
    if (mode_q == MODE_ASCII16) begin
      bank = ((r16 & LOW_MASK) << 1) | BANK_W'(a[13]);
    end else begin
      bank = bank_reg_q[page];
    end
    rom_cs_n   = ~(in_win & ~sltsl_n & ~rd_n);
    flash_a_hi = {outer_sel, bank};
  end

  assign bank_upd = bank_upd_q;

endmodule

// File: tb/tb_msx_rom_mapper_gen.sv
// Scoreboard bench for msx_rom_mapper_gen (BANK_W=6, SEL_W=1).
// Stimulus pushes expected bank_upd pulses and read addresses into a queue;
// a negedge monitor pops and compares whenever the DUT pulses bank_upd or
// asserts rom_cs_n.
module tb_msx_rom_mapper_gen;

  localparam int BANK_W = 6;
  localparam int SEL_W  = 1;
  localparam int FW     = SEL_W + BANK_W;

  typedef struct {
    logic          is_read;
    logic [FW-1:0] value;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    mode;
  logic [0:0]    outer_sel;
  logic [15:0]   a;
  logic [7:0]    d;
  logic          sltsl_n;
  logic          rd_n;
  logic          wr_n;
  logic          rom_cs_n;
  logic [FW-1:0] flash_a_hi;
  logic          bank_upd;
  logic [1:0]    mode_q;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  msx_rom_mapper_gen #(.BANK_W(BANK_W), .SEL_W(SEL_W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .outer_sel  (outer_sel),
    .a          (a),
    .d          (d),
    .sltsl_n    (sltsl_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .rom_cs_n   (rom_cs_n),
    .flash_a_hi (flash_a_hi),
    .bank_upd   (bank_upd),
    .mode_q     (mode_q)
  );

  always #5 clk = ~clk;

  // Advance n clocks and settle just after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // is_write: full Z80 write strobe; otherwise a one-cycle read.
  // expect_evt: push an expected bank_upd pulse (write) or read result (read).
  task automatic applyStimulus(input bit is_write, input logic [15:0] addr, input logic [7:0] data,
                               input bit expect_evt, input logic [FW-1:0] expect_val);
    exp_t e;
    if (expect_evt) begin
      e.is_read = ~is_write;
      e.value   = expect_val;
      exp_q.push_back(e);
    end
    a       = addr;
    d       = data;
    sltsl_n = 1'b0;
    if (is_write) begin
      wr_n = 1'b0;
      step(6);
      wr_n    = 1'b1;
      sltsl_n = 1'b1;
      step(4);
    end else begin
      rd_n = 1'b0;
      step(1);
      rd_n    = 1'b1;
      sltsl_n = 1'b1;
      step(1);
    end
  endtask

  task automatic doReset(input logic [1:0] m, input logic sel);
    reset_n   = 1'b0;
    mode      = m;
    outer_sel = sel;
    step(3);
    reset_n = 1'b1;
    step(5);
    checkOutput("reset_mode_q", {6'd0, mode_q}, {6'd0, m});
    checkOutput("reset_bank_upd", {7'd0, bank_upd}, 8'd0);
  endtask

  // Scoreboard monitor: every bank_upd pulse and every chip-select cycle consumes one entry.
  always @(negedge clk) begin
    if (bank_upd === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL upd_unexpected: got bank_upd=1 expected no pulse");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_read) begin
          mismatched++;
          $display("[TB] FAIL upd_order: got bank_upd pulse expected read of %0h", mon_e.value);
        end
      end
    end
    if (rom_cs_n === 1'b0) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL cs_unexpected: got rom_cs_n=0 a=%0h expected no select", a);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e.is_read) begin
          mismatched++;
          $display("[TB] FAIL read_order: got read a=%0h expected bank_upd pulse", a);
        end else if (flash_a_hi !== mon_e.value) begin
          mismatched++;
          $display("[TB] FAIL read a=%0h: got %0h expected %0h", a, flash_a_hi, mon_e.value);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    mode      = 2'd0;
    outer_sel = 1'b1;
    a         = 16'h0000;
    d         = 8'h00;
    sltsl_n   = 1'b1;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    step(2);

    $display("[TB] reset state, Konami-SCC");
    doReset(2'd0, 1'b1);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h40);
    applyStimulus(0, 16'h6000, 8'h00, 1, 7'h41);
    applyStimulus(0, 16'h8000, 8'h00, 1, 7'h42);
    applyStimulus(0, 16'hA000, 8'h00, 1, 7'h43);
    applyStimulus(0, 16'hC000, 8'h00, 0, 7'h00);
    a = 16'hC000; sltsl_n = 1'b0; rd_n = 1'b0; #1;
    checkOutput("cs_outside_window", {7'd0, rom_cs_n}, 8'd1);
    a = 16'h4000; sltsl_n = 1'b1; #1;
    checkOutput("cs_slot_deselected", {7'd0, rom_cs_n}, 8'd1);
    rd_n = 1'b1; step(1);

    $display("[TB] Konami-SCC writes");
    applyStimulus(1, 16'h5000, 8'h2A, 1, 7'h00);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h6A);
    applyStimulus(1, 16'h5800, 8'h3C, 0, 7'h00);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h6A);
    applyStimulus(0, 16'h6000, 8'h00, 1, 7'h41);

    $display("[TB] Konami writes");
    doReset(2'd1, 1'b1);
    applyStimulus(1, 16'h4000, 8'h07, 0, 7'h00);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h40);
    applyStimulus(1, 16'h6123, 8'h09, 1, 7'h00);
    applyStimulus(0, 16'h6000, 8'h00, 1, 7'h49);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h40);

    $display("[TB] ASCII16 width truncation");
    doReset(2'd3, 1'b0);
    applyStimulus(1, 16'h7000, 8'hFF, 1, 7'h00);
    applyStimulus(0, 16'h8000, 8'h00, 1, 7'h3E);
    applyStimulus(0, 16'hA000, 8'h00, 1, 7'h3F);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h00);
    applyStimulus(0, 16'h6000, 8'h00, 1, 7'h01);

    $display("[TB] ASCII8 writes and ignored mode change");
    doReset(2'd2, 1'b1);
    applyStimulus(1, 16'h6000, 8'h11, 1, 7'h00);
    applyStimulus(1, 16'h6800, 8'h22, 1, 7'h00);
    applyStimulus(1, 16'h7000, 8'h33, 1, 7'h00);
    applyStimulus(1, 16'h7800, 8'h0F, 1, 7'h00);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h51);
    applyStimulus(0, 16'h6000, 8'h00, 1, 7'h62);
    applyStimulus(0, 16'h8000, 8'h00, 1, 7'h73);
    applyStimulus(0, 16'hA000, 8'h00, 1, 7'h4F);
    mode = 2'd0;
    step(2);
    checkOutput("mode_q_hold", {6'd0, mode_q}, 8'd2);
    applyStimulus(1, 16'h5000, 8'h2A, 0, 7'h00);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h51);
    applyStimulus(0, 16'hA000, 8'h00, 1, 7'h4F);
    applyStimulus(1, 16'h6000, 8'hC5, 1, 7'h00);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h45);

    $display("[TB] reset during strobe");
    doReset(2'd0, 1'b1);
    a = 16'h5000; d = 8'h15; sltsl_n = 1'b0; wr_n = 1'b0;
    step(1);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(8);
    wr_n = 1'b1; sltsl_n = 1'b1;
    step(5);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h40);
    applyStimulus(1, 16'h5000, 8'h15, 1, 7'h00);
    applyStimulus(0, 16'h4000, 8'h00, 1, 7'h55);

    step(10);
    checkOutput("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
